// File: rtl/cs_out_buffer.sv
// Elastic output buffer behind the CS smoothing core: discards the warm-up samples,
// queues Y words in a first-word-fall-through FIFO and counts words lost to overflow.
module cs_out_buffer #(
    parameter int DEPTH  = 8,
    parameter int WARMUP = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [9:0]               y_in,
    input  logic                     flush,
    output logic [9:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overflow,
    output logic [7:0]               drop_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int WW = $clog2(WARMUP + 1);
    localparam logic [LW-1:0] FULL      = LW'(DEPTH);
    localparam logic [WW-1:0] WARM_DONE = WW'(WARMUP);

    logic [9:0]    mem [DEPTH];
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [9:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    drop_q, drop_d;
    logic          push, pop, wr_en;

    assign push = (wcnt_q == WARM_DONE) && !flush;
    assign pop  = valid_q && out_ready;

    always_comb begin
        wcnt_d  = wcnt_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;
        wr_en   = 1'b0;
        if (flush) begin
            wcnt_d  = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            data_d  = '0;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
            drop_d  = '0;
        end else begin
            if (wcnt_q != WARM_DONE) begin
                wcnt_d = wcnt_q + 1'b1;
            end
            // A full FIFO still accepts a word when the head leaves on the same edge.
            if (push && (pop || level_q != FULL)) begin
                wr_en  = 1'b1;
                wptr_d = wptr_q + 1'b1;
            end
            if (push && !pop && level_q == FULL) begin
                ovf_d = 1'b1;
                if (drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            if (wr_en && !pop) begin
                level_d = level_q + 1'b1;
            end else if (pop && !wr_en) begin
                level_d = level_q - 1'b1;
            end
            valid_d = (level_d != '0);
            // Registered head: bypass the incoming word when it lands in the head slot.
            if (level_d != '0) begin
                data_d = (wr_en && rptr_d == wptr_q) ? y_in : mem[rptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_q] <= y_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            wcnt_q  <= wcnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overflow  = ovf_q;
    assign drop_cnt  = drop_q;
    assign level     = level_q;

endmodule

// File: tb/tb_cs_out_buffer.sv
// Directed bench for cs_out_buffer: warm-up, stall/overflow, full push+pop, flush,
// async reset mid-stream and a long wrap-around stream against a queue reference.
module tb_cs_out_buffer;

    logic       clk;
    logic       reset;
    logic [9:0] y_in;
    logic       flush;
    logic [9:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic [3:0] level;

    int checks = 0;
    int errors = 0;
    int y_next = 1;

    cs_out_buffer #(.DEPTH(8), .WARMUP(9)) dut (
        .clk(clk), .reset(reset), .y_in(y_in), .flush(flush),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .drop_cnt(drop_cnt), .level(level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running exp finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        y_in = y_next[9:0];
        @(posedge clk);
        #1;
        y_next++;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        y_next = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0; y_in = '0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b exp 0", out_valid); end
        checks++; if (out_data !== 10'h000) begin errors++; $display("FAIL reset_data: got %0h exp 0", out_data); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d exp 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b exp 0", overflow); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d exp 0", drop_cnt); end
    endtask

    task automatic test_warmup();
        apply_reset();
        out_ready = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            tick();
            if (n < 10) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL warmup_valid edge %0d: got %0b exp 0", n, out_valid); end
            end else begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL warmup_valid edge %0d: got %0b exp 1", n, out_valid); end
                checks++; if (out_data !== 10'(n)) begin errors++; $display("FAIL warmup_data edge %0d: got %0h exp %0h", n, out_data, n); end
                checks++; if (level !== 4'd1) begin errors++; $display("FAIL warmup_level edge %0d: got %0d exp 1", n, level); end
            end
        end
    endtask

    task automatic test_stall_full();
        apply_reset();
        out_ready = 1'b0;
        repeat (17) tick();
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL stall_level: got %0d exp 8", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stall_ovf_early: got %0b exp 0", overflow); end
        checks++; if (out_data !== 10'd10) begin errors++; $display("FAIL stall_head: got %0d exp 10", out_data); end
        repeat (2) tick();
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL stall_level_drop: got %0d exp 8", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL stall_ovf: got %0b exp 1", overflow); end
        checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL stall_drop: got %0d exp 2", drop_cnt); end
        checks++; if (out_data !== 10'd10) begin errors++; $display("FAIL stall_head_kept: got %0d exp 10", out_data); end
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            checks++; if (out_data !== 10'(10 + j)) begin errors++; $display("FAIL drain_data %0d: got %0d exp %0d", j, out_data, 10 + j); end
            checks++; if (level !== 4'd8) begin errors++; $display("FAIL drain_level %0d: got %0d exp 8", j, level); end
            tick();
        end
        checks++; if (out_data !== 10'd20) begin errors++; $display("FAIL drain_next: got %0d exp 20", out_data); end
        checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL drain_drop: got %0d exp 2", drop_cnt); end
    endtask

    task automatic test_full_push_pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL pp_level: got %0d exp 8", level); end
        checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL pp_drop: got %0d exp 2", drop_cnt); end
        checks++; if (out_data !== 10'd21) begin errors++; $display("FAIL pp_head: got %0d exp 21", out_data); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b exp 0", out_valid); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL flush_level: got %0d exp 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_ovf: got %0b exp 0", overflow); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL flush_drop: got %0d exp 0", drop_cnt); end
        checks++; if (out_data !== 10'd0) begin errors++; $display("FAIL flush_data: got %0d exp 0", out_data); end
        // flush was edge 29; edges 30..38 discarded, edge 39 is the first push
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i < 10) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_warm %0d: got %0b exp 0", i, out_valid); end
            end
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_first_valid: got %0b exp 1", out_valid); end
        checks++; if (out_data !== 10'd39) begin errors++; $display("FAIL flush_first_data: got %0d exp 39", out_data); end
        repeat (4) tick();
        checks++; if (level !== 4'd5) begin errors++; $display("FAIL flush_level5: got %0d exp 5", level); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL flush2_level: got %0d exp 0", level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush2_valid: got %0b exp 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        repeat (12) tick();
        checks++; if (level !== 4'd3) begin errors++; $display("FAIL rmid_level_pre: got %0d exp 3", level); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %0b exp 0", out_valid); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL rmid_level: got %0d exp 0", level); end
        checks++; if (out_data !== 10'd0) begin errors++; $display("FAIL rmid_data: got %0d exp 0", out_data); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        y_next = 1;
        out_ready = 1'b1;
        repeat (9) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_warm: got %0b exp 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_first_valid: got %0b exp 1", out_valid); end
        checks++; if (out_data !== 10'd10) begin errors++; $display("FAIL rmid_first_data: got %0d exp 10", out_data); end
    endtask

    task automatic test_wrap();
        logic [9:0] q[$];
        int drops = 0;
        int k;
        int exp_drop;
        logic rdy, do_pop, do_push;
        logic [9:0] yv;
        apply_reset();
        for (int e = 1; e <= 2009; e++) begin
            k = (e - 1) % 5;
            rdy = (k == 1 || k == 4) ? 1'b0 : 1'b1;
            out_ready = rdy;
            checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL wrap_valid edge %0d: got %0b exp %0b", e, out_valid, q.size() != 0); end
            checks++; if (level !== 4'(q.size())) begin errors++; $display("FAIL wrap_level edge %0d: got %0d exp %0d", e, level, q.size()); end
            if (q.size() != 0) begin
                checks++; if (out_data !== q[0]) begin errors++; $display("FAIL wrap_data edge %0d: got %0h exp %0h", e, out_data, q[0]); end
            end
            do_pop  = (q.size() != 0) && rdy;
            do_push = (e >= 10);
            yv = y_next[9:0];
            tick();
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                if (q.size() < 8) q.push_back(yv);
                else drops++;
            end
        end
        exp_drop = (drops > 255) ? 255 : drops;
        checks++; if (drop_cnt !== 8'(exp_drop)) begin errors++; $display("FAIL wrap_drop: got %0d exp %0d", drop_cnt, exp_drop); end
        checks++; if (overflow !== (drops > 0)) begin errors++; $display("FAIL wrap_ovf: got %0b exp %0b", overflow, drops > 0); end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_stall_full();
        test_full_push_pop();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
